instr_dispatch: RTL and testbench
=================================

Name: instr_dispatch

Overview:
Control-unit sequencer that sits directly upstream of the per-instruction execution FSMs, such as MOVI, ADD and MOV.
- Fetches an instruction word from instruction memory and latches it in an instruction register.
- Decodes the opcode and pulses exactly one execution unit's start line.
- Waits for that unit's Done pulse, enforces a settle gap, then fetches the next instruction.
- Flags illegal opcodes and execution units that never respond.

Parameters:
INSTR_W, 16, instruction word width.
OPC_W, 4, opcode field width; the opcode is ir[INSTR_W-1 -: OPC_W].
NUM_UNITS, 8, number of execution FSMs; opcode value N selects unit N.
TIMEOUT_CYC, 15, cycles allowed in WAIT before timeout_err is raised.
GAP_CYC, 3, idle cycles between a unit's Done and the next start, covering the unit's return-to-Zero tail.

Ports:
clk  in  1  system clock; all state changes on the posedge.
reset  in  1  asynchronous, active-low reset.
run  in  1  level; enables continuous fetch/dispatch.
imem_data  in  INSTR_W  instruction word from memory.
imem_valid  in  1  imem_data is valid this cycle.
fetch_req  out  1  request to instruction memory.
ir_out  out  INSTR_W  latched instruction register; operand fields go to the execution units.
start_vec  out  NUM_UNITS  one-hot, single-cycle start pulse.
done_vec  in  NUM_UNITS  per-unit Done pulses.
busy  out  1  high in every state except IDLE.
illegal  out  1  sticky; opcode >= NUM_UNITS.
timeout_err  out  1  sticky; the selected unit gave no Done within TIMEOUT_CYC.

Behaviour:
- Reset (asynchronous, active-low): state=IDLE, ir_out=0, all counters=0. Outputs fetch_req=0, start_vec=0, busy=0, illegal=0, timeout_err=0.
- Reset asserted mid-instruction aborts immediately, with no start or fetch glitch. The downstream unit is reset by the same line.
- IDLE: all outputs low. run=1 -> FETCH.
- FETCH: fetch_req=1.
  - imem_valid=1: ir_out <= imem_data on that edge -> DECODE.
  - run dropping in FETCH -> IDLE with no capture.
- DECODE: one cycle; sel <= opcode.
  - opcode < NUM_UNITS -> ISSUE.
  - Otherwise: illegal <= 1 -> ERROR.
- ISSUE: start_vec[sel]=1 for exactly this one cycle; timer cleared -> WAIT.
- WAIT: start_vec=0; timer increments each cycle.
  - done_vec[sel]=1 -> GAP, whatever the timer value.
  - timer == TIMEOUT_CYC-1 without Done -> timeout_err <= 1 -> ERROR.
  - Done and timeout in the same cycle: Done wins.
  - done_vec bits other than sel are ignored.
  - done_vec is ignored during the ISSUE cycle.
  - run dropping in WAIT does not abort; the instruction completes.
- GAP: counts GAP_CYC cycles.
  - run=1 -> FETCH.
  - run=0 -> IDLE.
  - GAP_CYC=0 skips the state.
- Latency: the start pulse occurs 2 cycles after the imem_valid edge (DECODE, then ISSUE).
  - Minimum Done-to-next-start spacing is GAP_CYC+3 cycles.
- ERROR: busy=1; flags held.
  - run=0 -> IDLE, clearing illegal and timeout_err on exit.
  - ir_out holds the offending word for debug.
- ir_out changes only in FETCH on imem_valid.
- The timer saturates and never wraps.
- At most one start_vec bit is ever high.

Optional Feature:
DISPATCH_TRACE_EN
- Defined: adds output retired_cnt [15:0].
  - Increments on each accepted Done in WAIT.
  - Saturates at 16'hFFFF; reset to 0.
  - Illegal and timed-out instructions are not counted.
- Undefined: the port and counter are absent. Core behaviour is identical either way.

Decomposition:
- Package dispatch_pkg:
  - State encoding constants: IDLE, FETCH, DECODE, ISSUE, WAIT, GAP, ERROR (3-bit).
  - Opcode constants, e.g. OPC_MOVI.
  - Default widths.
- Sub-module dispatch_timer: clearable, saturating up-counter with a compare-equal output, instantiated once.
  - It is shared by WAIT (timeout) and GAP (settle), since the two never overlap.

Test Plan:
1. Reset low for 3 cycles, then high with run=0 -> all outputs 0, busy=0, state IDLE held.
2. run=1, imem_data=16'h2ABC with imem_valid -> ir_out=16'h2ABC next edge; start_vec=8'b0000_0100 for one cycle, 2 cycles after capture; done_vec[2] 4 cycles later -> fetch_req reasserts after 3 GAP cycles.
3. imem_data=16'hF000, NUM_UNITS=8 -> illegal=1, no start pulse; run=0 -> IDLE, illegal=0.
4. Issue unit 1 and never return Done -> timeout_err=1 exactly 15 cycles after WAIT entry; done_vec[3] pulses during WAIT are ignored.
5. Done on the final timeout cycle -> GAP taken, timeout_err stays 0; reset pulsed in WAIT -> immediate IDLE, start_vec=0.
6. With DISPATCH_TRACE_EN: 3 good instructions plus 1 illegal -> retired_cnt=3.

Source files
------------

// File: rtl/dispatch_pkg.sv
// Shared constants for the instruction dispatch sequencer.
// Optional build macro used by the top: DISPATCH_TRACE_EN (retired-instruction counter).
package dispatch_pkg;

    localparam int unsigned INSTR_W     = 16;
    localparam int unsigned OPC_W       = 4;
    localparam int unsigned NUM_UNITS   = 8;
    localparam int unsigned TIMEOUT_CYC = 15;
    localparam int unsigned GAP_CYC     = 3;
    localparam int unsigned STATE_W     = 3;

    localparam logic [STATE_W-1:0] IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] FETCH  = 3'd1;
    localparam logic [STATE_W-1:0] DECODE = 3'd2;
    localparam logic [STATE_W-1:0] ISSUE  = 3'd3;
    localparam logic [STATE_W-1:0] WAIT   = 3'd4;
    localparam logic [STATE_W-1:0] GAP    = 3'd5;
    localparam logic [STATE_W-1:0] ERROR  = 3'd6;

    // Opcode value N selects execution unit N.
    typedef enum logic [OPC_W-1:0] {
        OPC_MOVI = 4'd0,
        OPC_ADD  = 4'd1,
        OPC_MOV  = 4'd2
    } opcode_e;

    // Timer width able to reach the larger of the two compare targets.
    function automatic int unsigned tmr_width(input int unsigned timeout_cyc,
                                              input int unsigned gap_cyc);
        int unsigned m;
        m = (timeout_cyc > gap_cyc) ? timeout_cyc : gap_cyc;
        return (m < 2) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/dispatch_timer.sv
// Clearable, saturating up-counter with an equality compare; shared by WAIT and GAP.
module dispatch_timer #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] cmp_val,
    output logic         eq_c
);

    localparam logic [W-1:0] CNT_MAX = '1;

    logic [W-1:0] cnt;

    // Clear has priority over increment; the count holds at its maximum.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != CNT_MAX)) begin
            cnt <= cnt + W'(1);
        end
    end

    assign eq_c = (cnt == cmp_val);

endmodule

// File: rtl/instr_dispatch.sv
// Fetch / decode / issue sequencer feeding the per-instruction execution FSMs.
// Build option: define DISPATCH_TRACE_EN to add the retired_cnt output.
module instr_dispatch
    import dispatch_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run,
    input  logic [INSTR_W-1:0]   imem_data,
    input  logic                 imem_valid,
    output logic                 fetch_req,
    output logic [INSTR_W-1:0]   ir_out,
    output logic [NUM_UNITS-1:0] start_vec,
    input  logic [NUM_UNITS-1:0] done_vec,
    output logic                 busy,
    output logic                 illegal,
    output logic                 timeout_err
`ifdef DISPATCH_TRACE_EN
    ,
    output logic [15:0]          retired_cnt
`endif
);

    localparam int unsigned SEL_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam int unsigned TMR_W = tmr_width(TIMEOUT_CYC, GAP_CYC);
    localparam logic [TMR_W-1:0] TMO_CMP = TMR_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam logic [TMR_W-1:0] GAP_CMP = TMR_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    logic [STATE_W-1:0]   state, state_nxt;
    logic [INSTR_W-1:0]   ir_nxt;
    logic [SEL_W-1:0]     sel, sel_nxt;
    logic [NUM_UNITS-1:0] start_nxt;
    logic                 illegal_nxt, timeout_nxt;
    logic                 done_hit;
    logic                 tmr_clr, tmr_inc, tmr_eq;
    logic [TMR_W-1:0]     tmr_cmp;
    logic [OPC_W-1:0]     opcode;

    assign opcode = ir_out[INSTR_W-1 -: OPC_W];

    dispatch_timer #(.W(TMR_W)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (tmr_clr),
        .inc     (tmr_inc),
        .cmp_val (tmr_cmp),
        .eq_c    (tmr_eq)
    );

    // Next-state and next-output decode.
    always_comb begin
        state_nxt   = state;
        ir_nxt      = ir_out;
        sel_nxt     = sel;
        start_nxt   = '0;
        illegal_nxt = illegal;
        timeout_nxt = timeout_err;
        done_hit    = 1'b0;
        tmr_clr     = 1'b0;
        tmr_inc     = 1'b0;
        tmr_cmp     = TMO_CMP;

        case (state)
            IDLE: begin
                if (run) state_nxt = FETCH;
            end
            FETCH: begin
                if (!run) begin
                    state_nxt = IDLE;
                end else if (imem_valid) begin
                    ir_nxt    = imem_data;
                    state_nxt = DECODE;
                end
            end
            DECODE: begin
                if (32'(opcode) < NUM_UNITS) begin
                    sel_nxt   = SEL_W'(opcode);
                    start_nxt = NUM_UNITS'(1) << opcode;
                    state_nxt = ISSUE;
                end else begin
                    illegal_nxt = 1'b1;
                    state_nxt   = ERROR;
                end
            end
            ISSUE: begin
                tmr_clr   = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                tmr_inc  = 1'b1;
                done_hit = done_vec[sel];
                if (done_hit) begin
                    tmr_clr = 1'b1;
                    if (GAP_CYC == 0) state_nxt = run ? FETCH : IDLE;
                    else              state_nxt = GAP;
                end else if (tmr_eq) begin
                    timeout_nxt = 1'b1;
                    state_nxt   = ERROR;
                end
            end
            GAP: begin
                tmr_inc = 1'b1;
                tmr_cmp = GAP_CMP;
                if (tmr_eq) state_nxt = run ? FETCH : IDLE;
            end
            ERROR: begin
                if (!run) begin
                    illegal_nxt = 1'b0;
                    timeout_nxt = 1'b0;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and registered outputs; outputs track the state being entered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            ir_out      <= '0;
            sel         <= '0;
            start_vec   <= '0;
            fetch_req   <= 1'b0;
            busy        <= 1'b0;
            illegal     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            ir_out      <= ir_nxt;
            sel         <= sel_nxt;
            start_vec   <= start_nxt;
            fetch_req   <= (state_nxt == FETCH);
            busy        <= (state_nxt != IDLE);
            illegal     <= illegal_nxt;
            timeout_err <= timeout_nxt;
        end
    end

`ifdef DISPATCH_TRACE_EN
    // Count instructions whose unit returned Done; saturates.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retired_cnt <= '0;
        end else if (done_hit && (retired_cnt != 16'hFFFF)) begin
            retired_cnt <= retired_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_dispatch.sv
// Scoreboard bench for instr_dispatch: stimulus pushes expected events, a monitor pops them.
module tb_instr_dispatch;

    localparam int EV_START   = 0;
    localparam int EV_ILLEGAL = 1;
    localparam int EV_TIMEOUT = 2;

    typedef struct {
        int          kind;
        logic [7:0]  vec;
        logic [15:0] ir;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        run;
    logic [15:0] imem_data;
    logic        imem_valid;
    logic        fetch_req;
    logic [15:0] ir_out;
    logic [7:0]  start_vec;
    logic [7:0]  done_vec;
    logic        busy;
    logic        illegal;
    logic        timeout_err;
`ifdef DISPATCH_TRACE_EN
    logic [15:0] retired_cnt;
`endif

    int   n_chk  = 0;
    int   n_fail = 0;
    exp_t exp_q[$];
    logic prev_ill = 1'b0;
    logic prev_to  = 1'b0;

    instr_dispatch dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .imem_data   (imem_data),
        .imem_valid  (imem_valid),
        .fetch_req   (fetch_req),
        .ir_out      (ir_out),
        .start_vec   (start_vec),
        .done_vec    (done_vec),
        .busy        (busy),
        .illegal     (illegal),
        .timeout_err (timeout_err)
`ifdef DISPATCH_TRACE_EN
        ,
        .retired_cnt (retired_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int k, input logic [7:0] v, input logic [15:0] w);
        exp_t e;
        e.kind = k;
        e.vec  = v;
        e.ir   = w;
        exp_q.push_back(e);
    endtask

    task automatic sb_pop(input int k, input logic [7:0] v);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL sb_unexpected: got kind %0d vec %0h ir %0h, expected none", k, v, ir_out);
        end else begin
            e = exp_q.pop_front();
            chk("sb_kind", 32'(k), 32'(e.kind));
            chk("sb_vec", 32'(v), 32'(e.vec));
            chk("sb_ir", 32'(ir_out), 32'(e.ir));
        end
    endtask

    // Monitor: every start pulse and every flag rise must match the next expected event.
    always @(negedge clk) begin
        if (reset) begin
            if (start_vec != 8'h00) begin
                chk("start_onehot", 32'($countones(start_vec)), 32'd1);
                sb_pop(EV_START, start_vec);
            end
            if (illegal && !prev_ill) sb_pop(EV_ILLEGAL, 8'h00);
            if (timeout_err && !prev_to) sb_pop(EV_TIMEOUT, 8'h00);
        end
        prev_ill = illegal;
        prev_to  = timeout_err;
    end

    // Enter from FETCH; done after d WAIT cycles; returns in FETCH with run held high.
    task automatic exec_good(input logic [15:0] w, input logic [7:0] v, input int d);
        imem_data  = w;
        imem_valid = 1'b1;
        push_exp(EV_START, v, w);
        tick();
        imem_valid = 1'b0;
        tick();
        tick();
        repeat (d) tick();
        done_vec = v;
        tick();
        done_vec = 8'h00;
        repeat (3) tick();
        chk("good_refetch", 32'(fetch_req), 32'd1);
    endtask

    task automatic exec_illegal(input logic [15:0] w);
        imem_data  = w;
        imem_valid = 1'b1;
        push_exp(EV_ILLEGAL, 8'h00, w);
        tick();
        imem_valid = 1'b0;
        tick();
        chk("ill_flag", 32'(illegal), 32'd1);
        run = 1'b0;
        tick();
        run = 1'b1;
        tick();
    endtask

    initial begin
        reset      = 1'b0;
        run        = 1'b0;
        imem_data  = 16'h0000;
        imem_valid = 1'b0;
        done_vec   = 8'h00;

        // Reset state
        repeat (3) tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_fetch", 32'(fetch_req), 32'd0);
        chk("rst_start", 32'(start_vec), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_timeout", 32'(timeout_err), 32'd0);
        chk("rst_ir", 32'(ir_out), 32'd0);
        reset = 1'b1;
        repeat (3) tick();
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_fetch", 32'(fetch_req), 32'd0);

        // Normal dispatch to unit 2
        run = 1'b1;
        tick();
        chk("fetch_req", 32'(fetch_req), 32'd1);
        chk("fetch_busy", 32'(busy), 32'd1);
        imem_data  = 16'h2ABC;
        imem_valid = 1'b1;
        push_exp(EV_START, 8'h04, 16'h2ABC);
        tick();
        imem_valid = 1'b0;
        chk("capture_ir", 32'(ir_out), 32'h2ABC);
        chk("decode_nostart", 32'(start_vec), 32'd0);
        tick();
        chk("issue_start", 32'(start_vec), 32'h04);
        tick();
        chk("wait_nostart", 32'(start_vec), 32'd0);
        repeat (3) tick();
        done_vec = 8'h04;
        tick();
        done_vec = 8'h00;
        chk("gap0_fetch", 32'(fetch_req), 32'd0);
        tick();
        chk("gap1_fetch", 32'(fetch_req), 32'd0);
        tick();
        chk("gap2_fetch", 32'(fetch_req), 32'd0);
        tick();
        chk("gap_exit_fetch", 32'(fetch_req), 32'd1);

        // Illegal opcode
        imem_data  = 16'hF000;
        imem_valid = 1'b1;
        push_exp(EV_ILLEGAL, 8'h00, 16'hF000);
        tick();
        imem_valid = 1'b0;
        tick();
        chk("illegal_set", 32'(illegal), 32'd1);
        chk("error_busy", 32'(busy), 32'd1);
        chk("error_ir_hold", 32'(ir_out), 32'hF000);
        run = 1'b0;
        tick();
        chk("illegal_clr", 32'(illegal), 32'd0);
        chk("error_exit_busy", 32'(busy), 32'd0);

        // Timeout on unit 1, foreign Done ignored
        run = 1'b1;
        tick();
        imem_data  = 16'h1234;
        imem_valid = 1'b1;
        push_exp(EV_START, 8'h02, 16'h1234);
        push_exp(EV_TIMEOUT, 8'h00, 16'h1234);
        tick();
        imem_valid = 1'b0;
        tick();
        done_vec = 8'h02;
        tick();
        for (int i = 1; i <= 15; i++) begin
            done_vec = (i >= 3 && i <= 5) ? 8'h08 : 8'h00;
            tick();
            if (i == 14) chk("timeout_early", 32'(timeout_err), 32'd0);
            if (i == 15) begin
                chk("timeout_set", 32'(timeout_err), 32'd1);
                chk("timeout_busy", 32'(busy), 32'd1);
            end
        end
        done_vec = 8'h00;
        run = 1'b0;
        tick();
        chk("timeout_clr", 32'(timeout_err), 32'd0);

        // Done on final timeout cycle wins; run dropped in WAIT still completes
        run = 1'b1;
        tick();
        imem_data  = 16'h3001;
        imem_valid = 1'b1;
        push_exp(EV_START, 8'h08, 16'h3001);
        tick();
        imem_valid = 1'b0;
        tick();
        tick();
        run = 1'b0;
        repeat (14) tick();
        done_vec = 8'h08;
        tick();
        done_vec = 8'h00;
        chk("done_wins", 32'(timeout_err), 32'd0);
        chk("late_gap_busy", 32'(busy), 32'd1);
        repeat (3) tick();
        chk("late_gap_idle", 32'(busy), 32'd0);

        // Asynchronous reset in WAIT
        run = 1'b1;
        tick();
        imem_data  = 16'h5000;
        imem_valid = 1'b1;
        push_exp(EV_START, 8'h20, 16'h5000);
        tick();
        imem_valid = 1'b0;
        tick();
        tick();
        #2;
        reset = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_start", 32'(start_vec), 32'd0);
        chk("arst_fetch", 32'(fetch_req), 32'd0);
        chk("arst_ir", 32'(ir_out), 32'd0);
        run = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        chk("arst_idle", 32'(busy), 32'd0);

        // Three good instructions plus one illegal
        run = 1'b1;
        tick();
        exec_good(16'h0011, 8'h01, 0);
        exec_good(16'h4022, 8'h10, 5);
        exec_illegal(16'h8000);
        exec_good(16'h7FFF, 8'h80, 14);
`ifdef DISPATCH_TRACE_EN
        chk("retired_cnt", 32'(retired_cnt), 32'd3);
`endif
        run = 1'b0;
        repeat (2) tick();
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
